// File: rtl/uart_io_ctrl_pkg.sv
// Shared types for the uart I/O sequencer:
// FSM state encoding and the arbitration grant side.
package uart_io_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_STAT1  = 3'd4,
    R_STAT2  = 3'd5,
    R_DATA1  = 3'd6,
    R_DATA2  = 3'd7
  } state_t;

  typedef enum logic {
    GNT_TX = 1'b0,
    GNT_RX = 1'b1
  } gnt_t;

endpackage

// File: rtl/uart_io_ctrl_sync_fifo.sv
// Synchronous FIFO with exact occupancy count.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// Sequencer between CPU I/O port and the shared uart:
// TX drain, periodic RX polling, round-robin access arbitration.
module uart_io_ctrl
  import uart_io_ctrl_pkg::*;
#(
  parameter int TX_DEPTH      = 4,
  parameter int RX_DEPTH      = 4,
  parameter int POLL_INTERVAL = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [7:0]                  tx_data,
  output logic                        tx_ready,
  output logic                        rx_valid,
  output logic [7:0]                  rx_data,
  input  logic                        rx_pop,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        uart_sel_data,
  output logic                        uart_sel_status,
  output logic                        uart_rnw,
  output logic [7:0]                  uart_bus_out,
  output logic                        uart_bus_oe,
  input  logic [7:0]                  uart_bus_in
);

  localparam int TW = $clog2(POLL_INTERVAL);
  localparam logic [TW-1:0] TMR_RELOAD = TW'(POLL_INTERVAL - 1);

  state_t              r_state;
  gnt_t                r_prio;
  logic [TW-1:0]       r_timer;
  logic                r_sel_data;
  logic                r_sel_status;
  logic                r_rnw;
  logic                r_oe;
  logic [7:0]          r_bus_out;

  logic                      w_tx_full;
  logic                      w_tx_empty;
  logic [7:0]                w_tx_dout;
  logic [$clog2(TX_DEPTH):0] w_tx_count;
  logic                      w_tx_pop;
  logic                      w_rx_full;
  logic                      w_rx_empty;
  logic                      w_rx_push;
  logic                      w_tx_pend;
  logic                      w_poll_due;
  logic                      w_gnt_tx;
  logic                      w_gnt_rx;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_data),
    .full  (w_tx_full),
    .pop   (w_tx_pop),
    .dout  (w_tx_dout),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .din   (uart_bus_in),
    .full  (w_rx_full),
    .pop   (rx_pop),
    .dout  (rx_data),
    .empty (w_rx_empty),
    .count (rx_count)
  );

  assign tx_ready   = !w_tx_full;
  assign rx_valid   = !w_rx_empty;
  assign w_tx_pop   = (r_state == W_STROBE) && !w_tx_empty;
  assign w_rx_push  = (r_state == R_DATA2);
  assign w_tx_pend  = (w_tx_count != '0);
  assign w_poll_due = (r_timer == '0) && !w_rx_full;
  assign w_gnt_tx   = w_tx_pend && (!w_poll_due || r_prio == GNT_TX);
  assign w_gnt_rx   = w_poll_due && (!w_tx_pend || r_prio == GNT_RX);

  assign uart_sel_data   = r_sel_data;
  assign uart_sel_status = r_sel_status;
  assign uart_rnw        = r_rnw;
  assign uart_bus_out    = r_bus_out;
  assign uart_bus_oe     = r_oe;

  // Outputs are registered with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prio       <= GNT_TX;
      r_timer      <= TMR_RELOAD;
      r_sel_data   <= 1'b0;
      r_sel_status <= 1'b0;
      r_rnw        <= 1'b1;
      r_oe         <= 1'b0;
      r_bus_out    <= 8'h00;
    end else begin
      if (r_timer != '0) r_timer <= r_timer - 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_tx) begin
            r_state   <= W_SETUP;
            r_rnw     <= 1'b0;
            r_oe      <= 1'b1;
            r_bus_out <= w_tx_dout;
            r_prio    <= GNT_RX;
          end else if (w_gnt_rx) begin
            r_state      <= R_STAT1;
            r_sel_status <= 1'b1;
            r_prio       <= GNT_TX;
          end
        end
        W_SETUP: begin
          r_state    <= W_STROBE;
          r_sel_data <= 1'b1;
        end
        W_STROBE: begin
          r_state    <= W_HOLD;
          r_sel_data <= 1'b0;
        end
        // rnw rises one cycle after sel_data falls.
        W_HOLD: begin
          r_state <= IDLE;
          r_rnw   <= 1'b1;
          r_oe    <= 1'b0;
        end
        R_STAT1: r_state <= R_STAT2;
        R_STAT2: begin
          r_sel_status <= 1'b0;
          if (uart_bus_in != 8'h00 && !w_rx_full) begin
            r_state    <= R_DATA1;
            r_sel_data <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_timer <= TMR_RELOAD;
          end
        end
        R_DATA1: r_state <= R_DATA2;
        R_DATA2: begin
          r_state    <= IDLE;
          r_sel_data <= 1'b0;
          r_timer    <= TMR_RELOAD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
